// File: rtl/sig_delay_pkg.sv
// ---------------------------------------------------------------------------
// sig_pkg : shared definitions for the programmable-delay sample buffer.
//
// Contents
//   SIG_DATA_W  default sample width
//   SIG_ADDR_W  default RAM address width (depth = 2**SIG_ADDR_W)
//   state_t     fill state machine encoding {FILL, RUN}
// ---------------------------------------------------------------------------
package sig_pkg;

  localparam int SIG_DATA_W = 8;
  localparam int SIG_ADDR_W = 8;

  // FILL: waiting until `delay` fresh samples are in the RAM.
  // RUN : every strobe produces a valid delayed sample.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : sig_pkg

// File: rtl/sig_delay_ram2port.sv
// ---------------------------------------------------------------------------
// ram2port : simple dual-port RAM, one synchronous write port and one
// synchronous read port on the same clock. A read of the address being
// written in the same cycle returns the old contents. No reset, so it maps
// onto block RAM.
//
// Ports
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds its value while re=0
//   raddr  in   read address
//   rdata  out  registered read data (one cycle after re)
// ---------------------------------------------------------------------------
module ram2port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write and read in one process with non-blocking assignments: the read
  // sees the pre-write contents, giving read-old behaviour.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : ram2port

// File: rtl/sig_delay.sv
// ---------------------------------------------------------------------------
// sig_delay : programmable-delay sample buffer.
//
// Every strobed sample is written into a circular RAM; the sample written
// `delay` strobes earlier is read back. Output is qualified invalid (and
// forced to zero) until enough fresh samples for the current delay have
// been written since the last reset or delay change.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   synchronous reset, active low
//   en          in   sample strobe, one sample per cycle with en=1
//   din         in   input sample
//   delay       in   delay in strobes, 0 .. 2**ADDR_W-1
//   dout        out  delayed sample, 0 whenever dout_valid=0
//   dout_valid  out  dout holds a true delayed sample
//
// Latency: a strobe at edge t produces dout/dout_valid after edge t.
// ---------------------------------------------------------------------------
module sig_delay
  import sig_pkg::*;
#(
  parameter int DATA_W = SIG_DATA_W,
  parameter int ADDR_W = SIG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] delay,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] delay_q,    delay_d;
  state_t            state_q,    state_d;
  logic              byp_q,      byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic              valid_q,    valid_d;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic              chg;
  state_t            eff_state;
  logic [ADDR_W-1:0] eff_fill;
  logic [ADDR_W-1:0] rd_addr;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;

  // A delay change restarts the fill from scratch in the same cycle, so a
  // coincident strobe already counts as strobe 0 under the new delay.
  assign chg       = (delay != delay_q);
  assign eff_state = chg ? FILL : state_q;
  assign eff_fill  = chg ? '0   : fill_cnt_q;

  // Read address uses the pre-increment write pointer; modulo arithmetic
  // comes for free from the ADDR_W-bit subtraction.
  assign rd_addr = wr_ptr_q - delay;

  // Reset takes priority over the strobe: nothing is written or read while
  // rst is asserted. The read port only advances on strobes so ram_q holds
  // across en=0 gaps together with the other output registers.
  assign ram_we = en & rst;
  assign ram_re = en & rst;

  ram2port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = eff_fill;
    delay_d    = delay;
    state_d    = eff_state;
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    valid_d    = valid_q;

    if (en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;

      // At delay 0 the wanted sample is the one being written right now,
      // which a read-old RAM cannot return; take it straight from din.
      byp_d      = (delay == '0);
      byp_data_d = din;

      case (eff_state)
        FILL: begin
          if (eff_fill == delay) begin
            state_d = RUN;
            valid_d = 1'b1;
          end else begin
            fill_cnt_d = eff_fill + 1'b1;
            valid_d    = 1'b0;
          end
        end
        RUN: begin
          valid_d = 1'b1;
        end
        default: begin
          state_d = FILL;
          valid_d = 1'b0;
        end
      endcase
    end else if (chg) begin
      // No strobe, but the old delayed stream is no longer meaningful.
      valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      delay_q    <= '0;
      state_q    <= FILL;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      delay_q    <= delay_d;
      state_q    <= state_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      valid_q    <= valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output mux
  // -------------------------------------------------------------------------
  always_comb begin
    dout = '0;
    if (valid_q) begin
      dout = byp_q ? byp_data_q : ram_q;
    end
  end

  assign dout_valid = valid_q;

endmodule : sig_delay

// File: tb/tb_sig_delay.sv
// ---------------------------------------------------------------------------
// tb_sig_delay : scoreboard bench for sig_delay.
//
// The driver applies one cycle of inputs and pushes the response expected
// after the next rising edge, tagged with that cycle number. The monitor
// runs on the falling edge and pops every entry due in the current cycle.
// ---------------------------------------------------------------------------
module tb_sig_delay;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] delay;
  logic [7:0] dout;
  logic       dout_valid;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] dout;
    logic       valid;
    string      name;
  } exp_t;

  exp_t exp_q [$];

  sig_delay #(
    .DATA_W (8),
    .ADDR_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .delay      (delay),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s stale cyc=%0d want_cyc=%0d", e.name, cyc, e.cyc);
      end else begin
        if (dout_valid !== e.valid) begin
          failures++;
          $display("FAIL %s_valid cyc=%0d got=%0b want=%0b", e.name, cyc, dout_valid, e.valid);
        end
        checks++;
        if (dout !== e.dout) begin
          failures++;
          $display("FAIL %s_dout cyc=%0d got=%0d want=%0d", e.name, cyc, dout, e.dout);
        end else begin
          $display("ok %s cyc=%0d dout=%0d valid=%0b", e.name, cyc, dout, dout_valid);
        end
      end
    end
  end

  // Apply one cycle of inputs and record the response due after the edge.
  task automatic drive(input logic r, input logic e, input logic [7:0] d,
                       input logic [7:0] dl, input logic ev,
                       input logic [7:0] ed, input string nm);
    exp_t x;
    rst   = r;
    en    = e;
    din   = d;
    delay = dl;
    x.cyc   = cyc + 1;
    x.dout  = ed;
    x.valid = ev;
    x.name  = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    en    = 1'b0;
    din   = '0;
    delay = '0;
    @(posedge clk);
    #1;

    // Reset state
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, "reset");
    drive(1'b0, 1'b1, 8'd9, 8'd0, 1'b0, 8'd0, "reset_en");

    // Delay 0: bypass path, valid from the first strobe
    for (int n = 0; n < 10; n++)
      drive(1'b1, 1'b1, 8'(n), 8'd0, 1'b1, 8'(n), "d0");

    // Delay 4 after reset
    drive(1'b0, 1'b1, 8'h55, 8'd4, 1'b0, 8'd0, "rst4");
    for (int n = 0; n < 16; n++)
      drive(1'b1, 1'b1, 8'(n), 8'd4, n >= 4, (n >= 4) ? 8'(n - 4) : 8'd0, "d4");

    // Mid-run change 4 -> 10 coincident with a strobe
    for (int j = 0; j < 15; j++)
      drive(1'b1, 1'b1, 8'(100 + j), 8'd10, j >= 10,
            (j >= 10) ? 8'(100 + j - 10) : 8'd0, "chg10");

    // Change to 0 mid-run: valid immediately via bypass
    drive(1'b1, 1'b1, 8'd77, 8'd0, 1'b1, 8'd77, "chg0");
    drive(1'b1, 1'b1, 8'd78, 8'd0, 1'b1, 8'd78, "chg0");

    // Strobe gaps, delay 2: one strobe in three cycles
    drive(1'b0, 1'b0, 8'd0, 8'd2, 1'b0, 8'd0, "rstgap");
    for (int s = 0; s < 12; s++) begin
      logic       v;
      logic [7:0] x;
      v = (s >= 2);
      x = v ? 8'(50 + s - 2) : 8'd0;
      drive(1'b1, 1'b1, 8'(50 + s), 8'd2, v, x, "gap_strobe");
      drive(1'b1, 1'b0, 8'hEE, 8'd2, v, x, "gap_hold");
      drive(1'b1, 1'b0, 8'hDD, 8'd2, v, x, "gap_hold");
    end

    // Reset mid-run with a strobe present, then refill from zero
    drive(1'b0, 1'b1, 8'hAA, 8'd2, 1'b0, 8'd0, "rst_run");
    for (int j = 0; j < 6; j++)
      drive(1'b1, 1'b1, 8'(200 + j), 8'd2, j >= 2,
            (j >= 2) ? 8'(200 + j - 2) : 8'd0, "refill");

    // Wrap-around at maximum delay
    drive(1'b0, 1'b0, 8'd0, 8'd255, 1'b0, 8'd0, "rstwrap");
    for (int n = 0; n < 600; n++)
      drive(1'b1, 1'b1, 8'(n), 8'd255, n >= 255,
            (n >= 255) ? 8'(n - 255) : 8'd0, "wrap");

    // Delay change during a gap clears valid; the fill restarts from there
    drive(1'b1, 1'b0, 8'h33, 8'd3, 1'b0, 8'd0, "chg_gap");
    drive(1'b1, 1'b0, 8'h34, 8'd3, 1'b0, 8'd0, "chg_gap");
    for (int j = 0; j < 6; j++)
      drive(1'b1, 1'b1, 8'(10 + j), 8'd3, j >= 3,
            (j >= 3) ? 8'(10 + j - 3) : 8'd0, "post_gap");

    en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d want_done=1", cyc);
    $fatal(1, "timeout");
  end

endmodule : tb_sig_delay
